// File: rtl/udp_rx_pkt_buf.sv
// udp_rx_pkt_buf: single-packet store-and-forward buffer for UDP payload bytes.
// Payload bytes from the receive parser are written into a block RAM. When the
// end of the packet is seen, the stored payload is streamed to the consumer on
// a valid/ready interface through a two-stage prefetching read pipeline.
// Packets that overflow the RAM, or that arrive while a stored packet is still
// being streamed, are discarded and reported with a one-cycle pkt_drop pulse.
module udp_rx_pkt_buf #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        udp_rx_data,
  input  logic              udp_rx_en,
  input  logic              udp_rx_done,
  output logic [7:0]        m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [ADDR_W:0]   pkt_len,
  output logic              pkt_drop
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  // Control state
  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              edge_vld_q, edge_vld_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic              ovf_q, ovf_d;
  logic              disc_q, disc_d;
  logic [ADDR_W:0]   pkt_len_q, pkt_len_d;
  logic              pkt_drop_q, pkt_drop_d;

  // Read pipeline state
  logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;

  // Combinational strobes
  logic              en_rise;
  logic              done_rise;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic              out_adv;

  // Payload RAM
  logic [7:0]        mem [0:DEPTH-1];
  logic [7:0]        ram_rd_q;

  // Payload RAM: one write port from the receive side, one registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= udp_rx_data;
    end
    if (rd_en) begin
      ram_rd_q <= mem[rd_addr_q[ADDR_W-1:0]];
    end
  end

  // Rising-edge detection of the parser strobes. On the first cycle after reset
  // the delayed copies are not yet real samples, so no edge is reported; this
  // keeps the tail of a packet that was cut by reset from looking like a new one.
  always_comb begin
    en_d       = udp_rx_en;
    done_d     = udp_rx_done;
    edge_vld_d = 1'b1;
    en_rise    = udp_rx_en   & ~en_q   & edge_vld_q;
    done_rise  = udp_rx_done & ~done_q & edge_vld_q;
  end

  // Packet capture, commit and drop decisions plus next-state selection.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    ovf_d      = ovf_q;
    disc_d     = disc_q;
    pkt_len_d  = pkt_len_q;
    pkt_drop_d = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wr_cnt_q[ADDR_W-1:0];
    case (state_q)
      ST_IDLE: begin
        if (en_rise) begin
          // First byte of a new packet always lands at address 0.
          wr_en   = 1'b1;
          wr_addr = {ADDR_W{1'b0}};
          disc_d  = 1'b0;
          ovf_d   = 1'b0;
          if (done_rise) begin
            // Byte and end-of-packet together form a complete 1-byte packet.
            state_d   = ST_RD;
            pkt_len_d = CNT_ONE;
            wr_cnt_d  = CNT_ZERO;
          end else begin
            state_d  = ST_WR;
            wr_cnt_d = CNT_ONE;
          end
        end else if (done_rise && disc_q) begin
          // End of a packet that started while the previous one was streaming.
          pkt_drop_d = 1'b1;
          disc_d     = 1'b0;
        end else begin
          // A lone done edge here is an empty payload: nothing to report.
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (udp_rx_en && !wr_cnt_q[ADDR_W]) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
        end else if (udp_rx_en) begin
          // RAM full: keep the count pinned and stop writing instead of wrapping.
          ovf_d = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
        if (done_rise) begin
          if (ovf_d) begin
            state_d    = ST_IDLE;
            pkt_drop_d = 1'b1;
          end else begin
            state_d   = ST_RD;
            pkt_len_d = wr_cnt_d;
          end
          wr_cnt_d = CNT_ZERO;
          ovf_d    = 1'b0;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        if (m_valid_q && m_ready && m_last_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD;
        end
        // Packets arriving now cannot be stored; track them until their end.
        if (done_rise && (disc_q || en_rise)) begin
          pkt_drop_d = 1'b1;
          disc_d     = 1'b0;
        end else if (en_rise) begin
          disc_d = 1'b1;
        end else begin
          disc_d = disc_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_cnt_d = CNT_ZERO;
        ovf_d    = 1'b0;
        disc_d   = 1'b0;
      end
    endcase
  end

  // Read pipeline: the RAM output register is stage 1 and the m_* registers
  // are stage 2. Stage 1 refills whenever it is empty or is handing its byte
  // to stage 2, which gives one byte per cycle while m_ready stays high.
  always_comb begin
    out_adv   = ~m_valid_q | m_ready;
    rd_en     = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_vld_d  = rd_vld_q;
    rd_last_d = rd_last_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    if (state_q == ST_RD) begin
      rd_en = (rd_addr_q < pkt_len_q) && (~rd_vld_q || out_adv);
      if (rd_en) begin
        rd_addr_d = rd_addr_q + CNT_ONE;
        rd_vld_d  = 1'b1;
        rd_last_d = (rd_addr_q == (pkt_len_q - CNT_ONE));
      end else if (out_adv) begin
        rd_vld_d = 1'b0;
      end else begin
        rd_vld_d = rd_vld_q;
      end
      if (out_adv) begin
        m_valid_d = rd_vld_q;
        if (rd_vld_q) begin
          m_data_d = ram_rd_q;
          m_last_d = rd_last_q;
        end else begin
          m_last_d = 1'b0;
        end
      end else begin
        // Consumer stalled: hold the presented beat unchanged.
        m_valid_d = m_valid_q;
      end
    end else begin
      rd_addr_d = CNT_ZERO;
      rd_vld_d  = 1'b0;
      rd_last_d = 1'b0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      edge_vld_q <= 1'b0;
      wr_cnt_q   <= CNT_ZERO;
      ovf_q      <= 1'b0;
      disc_q     <= 1'b0;
      pkt_len_q  <= CNT_ZERO;
      pkt_drop_q <= 1'b0;
      rd_addr_q  <= CNT_ZERO;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      m_data_q   <= 8'h00;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      done_q     <= done_d;
      edge_vld_q <= edge_vld_d;
      wr_cnt_q   <= wr_cnt_d;
      ovf_q      <= ovf_d;
      disc_q     <= disc_d;
      pkt_len_q  <= pkt_len_d;
      pkt_drop_q <= pkt_drop_d;
      rd_addr_q  <= rd_addr_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign pkt_len  = pkt_len_q;
  assign pkt_drop = pkt_drop_q;

endmodule

// File: doc/udp_rx_pkt_buf.md
UDP_RX_PKT_BUF -- requirements
Module: udp_rx_pkt_buf

Interface
REQ-001 Parameter ADDR_W, default 11, log2 of payload buffer depth in bytes (2048).
REQ-002 clk  input  1  receive clock (same clock as the GMII receive parser); all logic on rising edge.
REQ-003 rstn  input  1  reset rstn, synchronous, active-low.
REQ-004 udp_rx_data  input  8  UDP payload byte from the parser, valid when udp_rx_en=1.
REQ-005 udp_rx_en  input  1  payload byte strobe, high for consecutive cycles of one packet.
REQ-006 udp_rx_done  input  1  end-of-packet indication; may stay high several cycles; only its rising edge is significant.
REQ-007 m_data  output  8  stored payload byte toward the consumer.
REQ-008 m_valid  output  1  m_data valid.
REQ-009 m_last  output  1  high with the final byte of the packet.
REQ-010 m_ready  input  1  consumer accepts; a beat transfers when m_valid&&m_ready.
REQ-011 pkt_len  output  ADDR_W+1  byte count of the packet currently being streamed.
REQ-012 pkt_drop  output  1  one-cycle pulse when a packet is discarded.

Function
REQ-013 The block SHALL register udp_rx_en and udp_rx_done once to detect rising edges (en_rise, done_rise).
REQ-014 States SHALL be IDLE, WR, RD; only one packet is stored at a time.
REQ-015 IDLE->WR on en_rise; the byte present in that cycle SHALL be written to address 0 and wr_cnt set to 1.
REQ-016 A rising edge of udp_rx_en SHALL be required to start a packet; if udp_rx_en is already high when IDLE is entered, the remaining bytes SHALL be ignored.
REQ-017 In WR, every cycle with udp_rx_en=1 SHALL write the byte at address wr_cnt and increment wr_cnt (ADDR_W+1 bits).
REQ-018 If wr_cnt reaches 2^ADDR_W and another byte arrives, an overflow flag SHALL set, further writes SHALL be suppressed, and no address wrap SHALL occur.
REQ-019 WR on done_rise: without overflow -> RD, pkt_len<=wr_cnt; with overflow -> IDLE with pkt_drop pulse.
REQ-020 done_rise in IDLE (zero-length payload) SHALL be ignored: no output, no pkt_drop.
REQ-021 In RD, m_valid SHALL first assert on the 2nd clock edge after the edge that moved the state to RD, presenting byte 0.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_last and m_valid SHALL hold stable.
REQ-023 With m_ready held high the block SHALL deliver one byte per cycle with no bubbles (prefetched read).
REQ-024 m_last SHALL be 1 only on byte index pkt_len-1; pkt_len SHALL hold stable throughout RD.
REQ-025 Transfer of the m_last beat SHALL deassert m_valid on the next cycle and return to IDLE; a new packet may begin on that cycle's en_rise.
REQ-026 Any en_rise occurring in RD SHALL start a discarded packet; its done_rise SHALL produce one pkt_drop pulse; stored data SHALL remain unaffected.
REQ-027 en and done rising in the same cycle in IDLE SHALL store that one byte and commit a 1-byte packet.
REQ-028 The buffer SHALL be a single-port-write/single-port-read RAM inferable as block RAM (registered read).

Reset
REQ-029 While rstn=0 at a clock edge: state IDLE, wr_cnt 0, overflow 0, edge registers 0, m_valid 0, m_last 0, m_data 0, pkt_len 0, pkt_drop 0.
REQ-030 Reset mid-packet or mid-stream SHALL discard the packet; RAM contents need not be cleared.

Verification
REQ-031 4-byte packet 11 22 33 44, m_ready=1 -> m_data 11,22,33,44 on consecutive cycles, m_last on 44, pkt_len=4, no pkt_drop.
REQ-032 Same packet, m_ready toggling 1,0,0,1... -> data stable during stalls, exactly 4 transfers, order preserved.
REQ-033 Second packet (8 bytes) arriving while first is streaming with m_ready=0 -> one pkt_drop pulse at its done; first packet delivered intact afterward.
REQ-034 ADDR_W=4, 17-byte packet -> pkt_drop pulse, m_valid never asserts; subsequent 16-byte packet delivered with pkt_len=16.
REQ-035 rstn low for one cycle after 3 bytes of a 10-byte packet -> all outputs 0; the packet's remaining bytes and done are ignored, no m_valid, no pkt_drop.
REQ-036 done held high 4 cycles after a 2-byte packet -> exactly one packet committed, pkt_len=2.
